// File: rtl/fetch_ctrl_pkg.sv
// Shared definitions for the instruction fetch controller.
//   fetch_state_t : controller FSM encoding (IDLE/RUN/DRAIN/DONE)
//   PC_STEP       : byte increment between consecutive instructions
//   PC_W          : width of fetch/program-counter addresses
//   RETIRE_LANES  : number of ROB retire strobes per cycle
package fetch_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } fetch_state_t;

  localparam int unsigned PC_STEP      = 4;
  localparam int unsigned PC_W         = 8;
  localparam int unsigned RETIRE_LANES = 2;

endpackage

// File: rtl/fetch_ctrl.sv
// Instruction fetch controller: walks a PROG_SIZE-byte program through a
// one-cycle-latency instruction memory, hands instructions to decode/rename
// when no back-end queue is full, then waits for every dispatched instruction
// to retire before reporting done.
//   clk, rst        : clock, synchronous active-high reset
//   start           : one-cycle pulse, IDLE -> RUN
//   iq_stall, rob_full, lsq_full : back-pressure from the back end
//   retire_valid    : per-lane ROB retire strobes
//   fetch_addr      : address presented to the instruction memory
//   instr_pc        : address of the word on the memory output
//   instr_valid     : memory output holds an undispatched instruction
//   dispatch_en     : instruction accepted this cycle
//   state, done     : FSM state and DONE indication
//   cycle_count     : cycles spent in RUN or DRAIN
//   stall_cycles    : cycles with a ready instruction blocked by back-pressure
//   underflow_err   : sticky, more retires than in-flight instructions
module fetch_ctrl
  import fetch_ctrl_pkg::*;
#(
  parameter int unsigned PROG_SIZE  = 72,
  parameter int unsigned INFLIGHT_W = 7
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic                    iq_stall,
  input  logic                    rob_full,
  input  logic                    lsq_full,
  input  logic [RETIRE_LANES-1:0] retire_valid,
  output logic [PC_W-1:0]         fetch_addr,
  output logic [PC_W-1:0]         instr_pc,
  output logic                    instr_valid,
  output logic                    dispatch_en,
  output logic [1:0]              state,
  output logic                    done,
  output logic [31:0]             cycle_count,
  output logic [31:0]             stall_cycles,
  output logic                    underflow_err
);

  localparam logic [PC_W-1:0] PROG_END = PC_W'(PROG_SIZE);
  localparam int unsigned     IW1      = INFLIGHT_W + 1;
  localparam int unsigned     RCW      = $clog2(RETIRE_LANES + 1);

  fetch_state_t          state_q;
  logic [PC_W-1:0]       next_pc_q;
  logic [PC_W-1:0]       instr_pc_q;
  logic                  instr_valid_q;
  logic [INFLIGHT_W-1:0] inflight_q;
  logic [INFLIGHT_W-1:0] inflight_d;
  logic [31:0]           cycle_count_q;
  logic [31:0]           stall_cycles_q;
  logic                  underflow_q;

  logic                  stall;
  logic                  in_run;
  logic                  slot_open;
  logic                  have_next;
  logic                  underflow_d;
  logic [RCW-1:0]        ret_cnt;
  logic [IW1-1:0]        inflight_sum;

  assign stall     = iq_stall | rob_full | lsq_full;
  assign in_run    = (state_q == RUN);
  assign have_next = (next_pc_q < PROG_END);

  // Reset gating keeps the memory address at 0 and suppresses any dispatch
  // while rst is high, so pending instructions are simply dropped.
  assign dispatch_en = ~rst & in_run & instr_valid_q & ~stall;
  assign slot_open   = in_run & (~instr_valid_q | dispatch_en);

  always_comb begin
    fetch_addr = instr_pc_q;
    if (rst) begin
      fetch_addr = '0;
    end else if (slot_open && have_next) begin
      fetch_addr = next_pc_q;
    end
  end

  always_comb begin
    ret_cnt = '0;
    for (int unsigned i = 0; i < RETIRE_LANES; i++) begin
      ret_cnt = ret_cnt + RCW'(retire_valid[i]);
    end
  end

  // Dispatch is added before retires are subtracted so a same-cycle
  // dispatch/retire pair never looks like an underflow.
  always_comb begin
    inflight_sum = {1'b0, inflight_q} + IW1'(dispatch_en);
    underflow_d  = (inflight_sum < IW1'(ret_cnt));
    if (underflow_d) begin
      inflight_d = '0;
    end else begin
      inflight_d = INFLIGHT_W'(inflight_sum - IW1'(ret_cnt));
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= IDLE;
      next_pc_q      <= '0;
      instr_pc_q     <= '0;
      instr_valid_q  <= 1'b0;
      inflight_q     <= '0;
      cycle_count_q  <= '0;
      stall_cycles_q <= '0;
      underflow_q    <= 1'b0;
    end else begin
      inflight_q <= inflight_d;
      if (underflow_d) begin
        underflow_q <= 1'b1;
      end
      case (state_q)
        IDLE: begin
          if (start) begin
            state_q <= RUN;
          end
        end
        RUN: begin
          cycle_count_q <= cycle_count_q + 32'd1;
          if (instr_valid_q && stall) begin
            stall_cycles_q <= stall_cycles_q + 32'd1;
          end
          if (slot_open) begin
            if (have_next) begin
              instr_pc_q    <= next_pc_q;
              instr_valid_q <= 1'b1;
              next_pc_q     <= next_pc_q + PC_W'(PC_STEP);
            end else begin
              instr_valid_q <= 1'b0;
              state_q       <= DRAIN;
            end
          end
        end
        DRAIN: begin
          cycle_count_q <= cycle_count_q + 32'd1;
          if (inflight_d == '0) begin
            state_q <= DONE;
          end
        end
        DONE: begin
          state_q <= DONE;
        end
      endcase
    end
  end

  assign instr_pc      = instr_pc_q;
  assign instr_valid   = instr_valid_q;
  assign state         = state_q;
  assign done          = ~rst & (state_q == DONE);
  assign cycle_count   = cycle_count_q;
  assign stall_cycles  = stall_cycles_q;
  assign underflow_err = underflow_q;

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed self-checking bench for fetch_ctrl (default 72-byte program plus
// a zero-length program instance sharing the same stimulus).
module tb_fetch_ctrl;

  logic        clk;
  logic        rst;
  logic        start;
  logic        iq_stall;
  logic        rob_full;
  logic        lsq_full;
  logic [1:0]  retire_valid;

  logic [7:0]  fetch_addr, instr_pc;
  logic        instr_valid, dispatch_en, done, underflow_err;
  logic [1:0]  state;
  logic [31:0] cycle_count, stall_cycles;

  logic [7:0]  fetch_addr0, instr_pc0;
  logic        instr_valid0, dispatch_en0, done0, underflow_err0;
  logic [1:0]  state0;
  logic [31:0] cycle_count0, stall_cycles0;

  int vecs = 0;
  int errs = 0;

  fetch_ctrl #(.PROG_SIZE(72), .INFLIGHT_W(7)) dut (
    .clk(clk), .rst(rst), .start(start), .iq_stall(iq_stall),
    .rob_full(rob_full), .lsq_full(lsq_full), .retire_valid(retire_valid),
    .fetch_addr(fetch_addr), .instr_pc(instr_pc), .instr_valid(instr_valid),
    .dispatch_en(dispatch_en), .state(state), .done(done),
    .cycle_count(cycle_count), .stall_cycles(stall_cycles),
    .underflow_err(underflow_err)
  );

  fetch_ctrl #(.PROG_SIZE(0), .INFLIGHT_W(7)) dut0 (
    .clk(clk), .rst(rst), .start(start), .iq_stall(iq_stall),
    .rob_full(rob_full), .lsq_full(lsq_full), .retire_valid(retire_valid),
    .fetch_addr(fetch_addr0), .instr_pc(instr_pc0), .instr_valid(instr_valid0),
    .dispatch_en(dispatch_en0), .state(state0), .done(done0),
    .cycle_count(cycle_count0), .stall_cycles(stall_cycles0),
    .underflow_err(underflow_err0)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vecs++;
    assert (got === exp) else begin
      errs++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, got, exp);
    end
  endtask

  task automatic reset_dut();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int  ndisp;
    bit  order_ok, saw_drain, h1, h2, h3;

    rst = 1'b1; start = 1'b0; iq_stall = 1'b0; rob_full = 1'b0;
    lsq_full = 1'b0; retire_valid = 2'b00;

    // Reset behaviour, including outputs while rst is still high.
    #1;
    chk("rst_fetch_addr", fetch_addr, 0);
    chk("rst_dispatch", dispatch_en, 0);
    chk("rst_done", done, 0);
    reset_dut();
    chk("rst_state", state, 0);
    chk("rst_valid", instr_valid, 0);
    chk("rst_cycles", cycle_count, 0);
    chk("rst_stalls", stall_cycles, 0);
    chk("rst_underflow", underflow_err, 0);

    // Full run, retire 3 cycles after each dispatch; zero-size instance in parallel.
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("run_entry", state, 1);
    chk("p0_run_entry", state0, 1);
    ndisp = 0; order_ok = 1; saw_drain = 0; h1 = 0; h2 = 0; h3 = 0;
    for (int cyc = 0; cyc < 60 && !done; cyc++) begin
      if (cyc == 1) chk("p0_drain", state0, 2);
      if (cyc == 2) chk("p0_done", state0, 3);
      if (dispatch_en) begin
        if (instr_pc !== 8'(ndisp * 4) || cyc != ndisp + 1) order_ok = 0;
        ndisp++;
      end
      if (state == 2'd2) saw_drain = 1;
      retire_valid = {1'b0, h3};
      h3 = h2; h2 = h1; h1 = dispatch_en;
      tick();
    end
    retire_valid = 2'b00;
    chk("full_dispatches", ndisp, 18);
    chk("full_order", order_ok, 1);
    chk("full_saw_drain", saw_drain, 1);
    chk("full_done", done, 1);
    chk("full_underflow", underflow_err, 0);
    chk("full_cycles", cycle_count, 22);
    chk("full_stalls", stall_cycles, 0);
    chk("full_inflight", dut.inflight_q, 0);
    chk("p0_done_hold", done0, 1);

    // iq_stall held five cycles at pc 8, then in-flight arithmetic.
    reset_dut();
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    tick();
    chk("stall_pre_pc", instr_pc, 8);
    iq_stall = 1'b1;
    #1;
    for (int i = 0; i < 5; i++) begin
      chk("stall_fetch_addr", fetch_addr, 8);
      chk("stall_no_dispatch", dispatch_en, 0);
      tick();
    end
    iq_stall = 1'b0;
    #1;
    chk("stall_count", stall_cycles, 5);
    chk("stall_pc_held", instr_pc, 8);
    chk("stall_release_disp", dispatch_en, 1);
    chk("stall_release_fetch", fetch_addr, 12);
    tick();
    chk("stall_next_pc", instr_pc, 12);
    chk("stall_next_disp", dispatch_en, 1);
    chk("infl_before", dut.inflight_q, 3);
    retire_valid = 2'b01;
    tick();
    retire_valid = 2'b00;
    chk("infl_disp_ret", dut.inflight_q, 3);
    chk("infl_pc16", instr_pc, 16);
    iq_stall = 1'b1;
    retire_valid = 2'b11;
    tick();
    chk("infl_dual_ret", dut.inflight_q, 1);
    tick();
    chk("infl_underflow_zero", dut.inflight_q, 0);
    chk("underflow_set", underflow_err, 1);
    retire_valid = 2'b00;
    iq_stall = 1'b0;
    tick();
    tick();
    chk("underflow_sticky", underflow_err, 1);
    chk("stall_total", stall_cycles, 7);

    // Reset in the middle of RUN at pc 40.
    reset_dut();
    chk("rst2_underflow", underflow_err, 0);
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 30; i++) begin
      if (instr_valid && instr_pc == 8'd40) break;
      tick();
    end
    chk("mid_reach_pc40", instr_pc, 40);
    rst = 1'b1;
    #1;
    chk("mid_rst_no_disp", dispatch_en, 0);
    chk("mid_rst_fetch", fetch_addr, 0);
    tick();
    rst = 1'b0;
    chk("mid_state", state, 0);
    chk("mid_fetch", fetch_addr, 0);
    chk("mid_cycles", cycle_count, 0);
    chk("mid_stalls", stall_cycles, 0);
    chk("mid_inflight", dut.inflight_q, 0);
    chk("mid_valid", instr_valid, 0);
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("restart_state", state, 1);
    chk("restart_fetch", fetch_addr, 0);
    tick();
    chk("restart_pc", instr_pc, 0);
    chk("restart_valid", instr_valid, 1);

    // rob_full on the final instruction, then drain and ignored start in DONE.
    for (int i = 0; i < 30; i++) begin
      if (instr_valid && instr_pc == 8'd68) break;
      tick();
    end
    chk("last_reach_pc68", instr_pc, 68);
    rob_full = 1'b1;
    #1;
    for (int i = 0; i < 4; i++) begin
      chk("last_hold_run", state, 1);
      chk("last_no_disp", dispatch_en, 0);
      tick();
    end
    rob_full = 1'b0;
    #1;
    chk("last_disp", dispatch_en, 1);
    tick();
    chk("last_drain", state, 2);
    chk("last_inflight", dut.inflight_q, 18);
    retire_valid = 2'b11;
    for (int i = 0; i < 8; i++) tick();
    chk("last_still_drain", state, 2);
    tick();
    retire_valid = 2'b00;
    chk("last_done_state", state, 3);
    chk("last_done", done, 1);
    chk("last_underflow", underflow_err, 0);
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    chk("done_ignores_start", state, 3);
    chk("done_stays", done, 1);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule

// File: doc/fetch_ctrl.md
FETCH_CTRL -- requirements
Module: fetch_ctrl

Interface
REQ-001 Parameter PROG_SIZE, default 72: program length in bytes; legal values are multiples of 4, at most 252.
REQ-002 Parameter INFLIGHT_W, default 7: width of the in-flight instruction counter.
REQ-003 clk  input  1  clock; every register updates on the rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 start  input  1  one-cycle pulse that begins program execution.
REQ-006 iq_stall  input  1  issue queue cannot accept an instruction.
REQ-007 rob_full  input  1  ROB cannot accept an instruction.
REQ-008 lsq_full  input  1  load/store queue cannot accept an instruction.
REQ-009 retire_valid  input  2  per-lane ROB retire strobes.
REQ-010 fetch_addr  output  8  byte address driving the synchronous instruction memory.
REQ-011 instr_pc  output  8  address of the instruction currently on the memory output.
REQ-012 instr_valid  output  1  memory output holds a fetched, undispatched instruction.
REQ-013 dispatch_en  output  1  decode/rename accept the instruction this cycle; rename stall_in is driven from ~dispatch_en.
REQ-014 state  output  2  FSM state: IDLE=0, RUN=1, DRAIN=2, DONE=3.
REQ-015 done  output  1  high iff state==DONE.
REQ-016 cycle_count  output  32  number of cycles spent in RUN or DRAIN.
REQ-017 stall_cycles  output  32  number of cycles in which an instruction was ready but blocked.
REQ-018 underflow_err  output  1  sticky flag: retires exceeded in-flight instructions.

Function
REQ-019 Internal stall: stall = iq_stall | rob_full | lsq_full.
REQ-020 Dispatch rule: dispatch_en = (state==RUN) & instr_valid & ~stall, evaluated combinationally.
REQ-021 A fetch slot opens when state==RUN and either instr_valid==0 or dispatch_en==1.
REQ-022 When a slot opens and next_pc < PROG_SIZE: fetch_addr = next_pc; on the clock edge, instr_pc <= next_pc, instr_valid <= 1, and next_pc <= next_pc + 4.
REQ-023 When a slot opens and next_pc == PROG_SIZE: fetch_addr = instr_pc and instr_valid <= 0.
REQ-024 When instr_valid & stall in RUN: fetch_addr = instr_pc, so the same word is re-read; instr_pc, instr_valid and next_pc hold.
REQ-025 Memory latency is one cycle: the instruction at fetch_addr in cycle t is valid in cycle t+1.
REQ-026 In IDLE, DRAIN and DONE: fetch_addr = instr_pc and no fetch state changes.
REQ-027 IDLE to RUN: on start. start is ignored in every other state.
REQ-028 RUN to DRAIN: on the edge where next_pc == PROG_SIZE and a slot opens, i.e. the last instruction has dispatched or none is pending.
REQ-029 DRAIN to DONE: when the in-flight count, including same-cycle retires, reaches 0.
REQ-030 DONE holds until rst.
REQ-031 In-flight counter: inflight <= inflight + dispatch_en - popcount(retire_valid), with simultaneous dispatch and retire allowed.
REQ-032 Underflow: if the subtraction would go below 0, inflight <= 0 and underflow_err <= 1; underflow_err stays set until rst.
REQ-033 The inflight counter never increments past 2^INFLIGHT_W-1; rob_full guarantees this bound.
REQ-034 cycle_count increments in RUN and DRAIN and wraps modulo 2^32.
REQ-035 stall_cycles increments when state==RUN & instr_valid & stall, and wraps modulo 2^32.
REQ-036 PROG_SIZE==0: the first RUN cycle transitions directly to DRAIN, then to DONE.

Reset
REQ-037 On rst, all of the following take effect on the next edge regardless of state: state=IDLE, next_pc=0, instr_pc=0, instr_valid=0, inflight=0, cycle_count=0, stall_cycles=0, underflow_err=0.
REQ-038 During and after reset: fetch_addr=0, dispatch_en=0, done=0.
REQ-039 A reset mid-RUN or mid-DRAIN discards pending instructions; no dispatch_en occurs in the reset cycle.

Structure
REQ-040 The shared package holds the fetch_state_t enum (IDLE/RUN/DRAIN/DONE), PC_STEP=4, PC_W=8 and the retire lane count of 2.
REQ-041 The block is a single module with no sub-modules; popcount is inline logic.
REQ-042 The FSM, PC registers and counters live in one sequential process; fetch_addr and dispatch_en are combinational.

Verification
REQ-043 PROG_SIZE=72, no stalls, start at cycle 0, one retire per cycle, each 3 cycles after its dispatch -> 18 dispatches with instr_pc 0,4,...,68 on consecutive cycles, then DRAIN, done=1, underflow_err=0.
REQ-044 Hold iq_stall for 5 cycles while instr_pc=8 -> fetch_addr=8 throughout the stall, instr_pc stays 8, stall_cycles=5, then dispatch at 8 followed by 12.
REQ-045 Dispatch and a retire in the same cycle at inflight=3 -> inflight stays 3; a dual retire with no dispatch -> inflight=1.
REQ-046 A dual retire at inflight=1 -> inflight=0, underflow_err=1, and the flag persists until rst.
REQ-047 rst asserted during RUN at instr_pc=40 -> next cycle state=IDLE, fetch_addr=0, all counters 0; a new start refetches from address 0.
REQ-048 rob_full held through the final instruction (instr_pc=68) -> state stays RUN, no DRAIN until 68 dispatches; start pulsed in DONE -> ignored.
